lc3_controller: RTL and testbench

//  Central multicycle sequencer for the LC3 core. Steps each instruction through FETCH, DECODE,

---
 rtl/lc3_controller.sv | 145 ++++++++++++++
 tb/tb_lc3_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lc3_controller.sv
// rtl/lc3_controller.sv - LC3 multicycle sequencer: stage enables, memory state, branch resolve.
// Optional bounded memory waits with mem_err reporting when LC3_CTRL_TIMEOUT_EN is defined.
module lc3_controller #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] IR,
    input  logic [2:0]  psr,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        enable_updatePC,
    output logic        br_taken,
    output logic [1:0]  mem_state,
    output logic        mem_err
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEMIND = 3'd3;
    localparam logic [2:0] S_MEMRD  = 3'd4;
    localparam logic [2:0] S_MEMWR  = 3'd5;
    localparam logic [2:0] S_WB     = 3'd6;
    localparam logic [2:0] S_UPDPC  = 3'd7;

    logic [2:0] state_q, state_d;
    logic       br_q, br_d;
    logic       ind_store_q, ind_store_d;

    // Only the opcode and the BR condition field steer sequencing.
    logic unused_ir;
    assign unused_ir = ^IR[8:0];

`ifdef LC3_CTRL_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       waiting;
    logic       wait_done;

    assign waiting = (state_q == S_FETCH) || (state_q == S_MEMIND) ||
                     (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign wait_done = (state_q == S_FETCH) ? complete_instr : complete_data;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = MEM_TIMEOUT;
`endif

    always_comb begin
        state_d     = state_q;
        br_d        = br_q;
        ind_store_d = ind_store_q;
        case (state_q)
            S_FETCH:  if (complete_instr) state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                br_d        = 1'b0;
                ind_store_d = IR[12];
                case (IR[15:12])
                    4'b0001, 4'b0101, 4'b1001, 4'b1110: state_d = S_WB;
                    4'b0000: begin
                        state_d = S_UPDPC;
                        br_d    = |(IR[11:9] & psr);
                    end
                    4'b1100: begin
                        state_d = S_UPDPC;
                        br_d    = 1'b1;
                    end
                    4'b0010, 4'b0110: state_d = S_MEMRD;
                    4'b0011, 4'b0111: state_d = S_MEMWR;
                    4'b1010, 4'b1011: state_d = S_MEMIND;
                    default:          state_d = S_UPDPC;
                endcase
            end
            // LDI and STI differ only in IR[12], captured at execute.
            S_MEMIND: if (complete_data) state_d = ind_store_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (complete_data) state_d = S_WB;
            S_MEMWR:  if (complete_data) state_d = S_UPDPC;
            S_WB:     state_d = S_UPDPC;
            S_UPDPC:  state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
`ifdef LC3_CTRL_TIMEOUT_EN
        err_d = 1'b0;
        // A completion in the final allowed cycle still wins over the timeout.
        if (waiting && !wait_done && (cnt_q == TIMEOUT_LIM)) begin
            state_d = S_UPDPC;
            br_d    = 1'b0;
            err_d   = 1'b1;
        end
        cnt_d = (waiting && (state_d == state_q)) ? cnt_q + 8'd1 : 8'd0;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_FETCH;
            br_q        <= 1'b0;
            ind_store_q <= 1'b0;
`ifdef LC3_CTRL_TIMEOUT_EN
            cnt_q       <= 8'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            br_q        <= br_d;
            ind_store_q <= ind_store_d;
`ifdef LC3_CTRL_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    // Outputs are masked while reset is held so downstream stages stay idle.
    always_comb begin
        enable_fetch     = !reset && (state_q == S_FETCH);
        enable_decode    = !reset && (state_q == S_DECODE);
        enable_execute   = !reset && (state_q == S_EXEC);
        enable_writeback = !reset && (state_q == S_WB);
        enable_updatePC  = !reset && (state_q == S_UPDPC);
        br_taken         = !reset && (state_q == S_UPDPC) && br_q;
        mem_state        = 2'd3;
        if (!reset) begin
            case (state_q)
                S_MEMRD:  mem_state = 2'd0;
                S_MEMIND: mem_state = 2'd1;
                S_MEMWR:  mem_state = 2'd2;
                default:  mem_state = 2'd3;
            endcase
        end
`ifdef LC3_CTRL_TIMEOUT_EN
        mem_err = !reset && (state_q == S_UPDPC) && err_q;
`else
        mem_err = 1'b0;
`endif
    end

endmodule

// File: tb/tb_lc3_controller.sv
// tb/tb_lc3_controller.sv - scoreboard bench for lc3_controller; per-cycle expected outputs queued with stimulus.
module tb_lc3_controller;

    logic        clock;
    logic        reset;
    logic        complete_instr;
    logic        complete_data;
    logic [15:0] IR;
    logic [2:0]  psr;
    logic        enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC;
    logic        br_taken;
    logic [1:0]  mem_state;
    logic        mem_err;

    lc3_controller #(.MEM_TIMEOUT(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .complete_instr   (complete_instr),
        .complete_data    (complete_data),
        .IR               (IR),
        .psr              (psr),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .enable_updatePC  (enable_updatePC),
        .br_taken         (br_taken),
        .mem_state        (mem_state),
        .mem_err          (mem_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0] en;
        logic [1:0] ms;
        logic       br;
        logic       err;
        logic       ci;
        logic       cd;
        logic       rst;
    } entry_t;

    localparam logic [4:0] EF = 5'b10000;
    localparam logic [4:0] ED = 5'b01000;
    localparam logic [4:0] EE = 5'b00100;
    localparam logic [4:0] EW = 5'b00010;
    localparam logic [4:0] EU = 5'b00001;
    localparam logic [4:0] EM = 5'b00000;

    entry_t exp_q[$];
    int     errors = 0;
    int     checks = 0;

    task automatic p(input logic [4:0] en, input logic [1:0] ms, input logic br,
                     input logic err, input logic ci, input logic cd, input logic rst);
        entry_t e;
        e.en = en; e.ms = ms; e.br = br; e.err = err; e.ci = ci; e.cd = cd; e.rst = rst;
        exp_q.push_back(e);
    endtask

    // Drive each entry's inputs at the falling edge, then check that cycle's outputs.
    task automatic run(input string tag);
        entry_t     e;
        logic [8:0] obs;
        logic [8:0] want;
        int         step;
        step = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clock);
            reset          = e.rst;
            complete_instr = e.ci;
            complete_data  = e.cd;
            #1;
            obs  = {enable_fetch, enable_decode, enable_execute, enable_writeback,
                    enable_updatePC, mem_state, br_taken, mem_err};
            want = {e.en, e.ms, e.br, e.err};
            checks++;
            assert (obs === want) else begin
                errors++;
                $error("FAIL %s step %0d: got en=%b ms=%0d br=%b err=%b, want en=%b ms=%0d br=%b err=%b",
                       tag, step, obs[8:4], obs[3:2], obs[1], obs[0],
                       want[8:4], want[3:2], want[1], want[0]);
            end
            step++;
        end
    endtask

    initial begin
        reset = 1'b1; complete_instr = 1'b0; complete_data = 1'b0;
        IR = 16'h0000; psr = 3'b000;

        p(EM, 2'd3, 0, 0, 1, 1, 1);
        p(EM, 2'd3, 0, 0, 1, 1, 1);
        p(EF, 2'd3, 0, 0, 1, 0, 0);
        p(ED, 2'd3, 0, 0, 1, 0, 0);
        p(EE, 2'd3, 0, 0, 1, 0, 0);
        p(EW, 2'd3, 0, 0, 1, 0, 0);
        p(EU, 2'd3, 0, 0, 1, 0, 0);
        IR = 16'h1042;
        run("reset_add");

        IR = 16'h0E05; psr = 3'b010;
        p(EF, 2'd3, 0, 0, 1, 1, 0); p(ED, 2'd3, 0, 0, 1, 1, 0);
        p(EE, 2'd3, 0, 0, 1, 1, 0); p(EU, 2'd3, 1, 0, 1, 1, 0);
        run("br_nzp_taken");

        IR = 16'h0805;
        p(EF, 2'd3, 0, 0, 1, 0, 0); p(ED, 2'd3, 0, 0, 1, 0, 0);
        p(EE, 2'd3, 0, 0, 1, 0, 0); p(EU, 2'd3, 0, 0, 1, 0, 0);
        run("br_n_not_taken");

        IR = 16'hC1C0;
        p(EF, 2'd3, 0, 0, 1, 0, 0); p(ED, 2'd3, 0, 0, 1, 0, 0);
        p(EE, 2'd3, 0, 0, 1, 0, 0); p(EU, 2'd3, 1, 0, 1, 0, 0);
        run("jmp");

        IR = 16'hD000;
        p(EF, 2'd3, 0, 0, 1, 0, 0); p(ED, 2'd3, 0, 0, 1, 0, 0);
        p(EE, 2'd3, 0, 0, 1, 0, 0); p(EU, 2'd3, 0, 0, 1, 0, 0);
        run("nop_clears_br");

        IR = 16'h2000;
        p(EF, 2'd3, 0, 0, 1, 0, 0); p(ED, 2'd3, 0, 0, 1, 0, 0);
        p(EE, 2'd3, 0, 0, 1, 0, 0); p(EM, 2'd0, 0, 0, 1, 1, 0);
        p(EW, 2'd3, 0, 0, 1, 0, 0); p(EU, 2'd3, 0, 0, 1, 0, 0);
        run("ld_zero_wait");

        IR = 16'h7000;
        p(EF, 2'd3, 0, 0, 1, 0, 0); p(ED, 2'd3, 0, 0, 1, 0, 0);
        p(EE, 2'd3, 0, 0, 1, 0, 0); p(EM, 2'd2, 0, 0, 1, 1, 0);
        p(EU, 2'd3, 0, 0, 1, 0, 0);
        run("str_zero_wait");

        IR = 16'hA003;
        p(EF, 2'd3, 0, 0, 1, 0, 0); p(ED, 2'd3, 0, 0, 1, 0, 0);
        p(EE, 2'd3, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) p(EM, 2'd1, 0, 0, 1, (i == 3), 0);
        for (int i = 0; i < 4; i++) p(EM, 2'd0, 0, 0, 1, (i == 3), 0);
        p(EW, 2'd3, 0, 0, 1, 0, 0); p(EU, 2'd3, 0, 0, 1, 0, 0);
        run("ldi_delayed");

        IR = 16'hB000;
        p(EF, 2'd3, 0, 0, 1, 0, 0); p(ED, 2'd3, 0, 0, 1, 0, 0);
        p(EE, 2'd3, 0, 0, 1, 0, 0); p(EM, 2'd1, 0, 0, 1, 1, 0);
        p(EM, 2'd2, 0, 0, 1, 1, 0); p(EU, 2'd3, 0, 0, 1, 0, 0);
        run("sti_zero_wait");

        IR = 16'h5042;
        p(EF, 2'd3, 0, 0, 0, 1, 0); p(EF, 2'd3, 0, 0, 0, 1, 0);
        p(EF, 2'd3, 0, 0, 1, 0, 0); p(ED, 2'd3, 0, 0, 0, 0, 0);
        p(EE, 2'd3, 0, 0, 0, 0, 0); p(EW, 2'd3, 0, 0, 0, 0, 0);
        p(EU, 2'd3, 0, 0, 1, 0, 0);
        run("and_fetch_wait");

        IR = 16'h3003;
        p(EF, 2'd3, 0, 0, 1, 0, 0); p(ED, 2'd3, 0, 0, 1, 0, 0);
        p(EE, 2'd3, 0, 0, 1, 0, 0); p(EM, 2'd2, 0, 0, 1, 0, 0);
        p(EM, 2'd3, 0, 0, 1, 1, 1); p(EM, 2'd3, 0, 0, 1, 1, 1);
        p(EF, 2'd3, 0, 0, 1, 0, 0); p(ED, 2'd3, 0, 0, 1, 0, 0);
        run("st_reset_mid_write");

`ifdef LC3_CTRL_TIMEOUT_EN
        IR = 16'h3003;
        p(EE, 2'd3, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) p(EM, 2'd2, 0, 0, 1, (i == 3), 0);
        p(EU, 2'd3, 0, 0, 1, 0, 0);
        run("st_complete_at_limit");

        IR = 16'h6000;
        p(EF, 2'd3, 0, 0, 1, 0, 0); p(ED, 2'd3, 0, 0, 1, 0, 0);
        p(EE, 2'd3, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) p(EM, 2'd0, 0, 0, 1, 0, 0);
        p(EU, 2'd3, 0, 1, 1, 0, 0); p(EF, 2'd3, 0, 0, 1, 0, 0);
        run("ldr_timeout");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
